// File: rtl/sd_dac_multi.sv
// rtl/sd_dac_multi.sv - multi-channel first/second-order sigma-delta DAC with staged sample handshake
module sd_dac_multi #(
  parameter int   MSBI      = 7,
  parameter int   CHANNELS  = 2,
  parameter logic INV       = 1'b1,
  parameter logic SIGNED_IN = 1'b0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         CE,
  input  logic                         ORDER2,
  input  logic                         MUTE,
  input  logic                         S_VALID,
  output logic                         S_READY,
  input  logic [CHANNELS*(MSBI+1)-1:0] S_DATA,
  output logic [CHANNELS-1:0]          DACout
);

  localparam int SW = MSBI + 1;
  localparam int AW = MSBI + 5;
  // Two guard bits so A2 + A1' + fb can never overflow before clamping
  localparam int EW = AW + 2;

  localparam logic signed [EW-1:0] LIM_P = EW'(2 ** (MSBI + 3));
  localparam logic signed [EW-1:0] LIM_N = -LIM_P;
  localparam logic signed [EW-1:0] FB_P  = EW'(2 ** MSBI);
  localparam logic signed [EW-1:0] FB_N  = -FB_P;

  // Excess-2**MSBI samples become two's complement by flipping the MSB; the
  // same constant is the raw sample that means x = 0 in either format.
  localparam logic [SW-1:0] SIGN_FLIP = SIGNED_IN ? {SW{1'b0}} : SW'(2 ** MSBI);
  localparam logic [SW-1:0] MID       = SIGN_FLIP;

  logic [CHANNELS*SW-1:0] stage_q, stage_d;
  logic [CHANNELS*SW-1:0] active_q, active_d;
  logic                   stage_full_q, stage_full_d;
  logic                   order_last_q;
  logic                   order_clear;
  logic                   accept, xfer;
  logic [CHANNELS-1:0]    dac_d;

  assign S_READY     = ~stage_full_q & ~RESET;
  assign accept      = S_VALID & S_READY;
  assign xfer        = CE & stage_full_q;
  assign order_clear = ORDER2 ^ order_last_q;

  function automatic logic signed [AW-1:0] sat(input logic signed [EW-1:0] v);
    logic signed [EW-1:0] c;
    if (v > LIM_P)      c = LIM_P;
    else if (v < LIM_N) c = LIM_N;
    else                c = v;
    return AW'(c);
  endfunction

  // Next state of the staging/active sample pipeline
  always_comb begin
    stage_d      = stage_q;
    active_d     = active_q;
    stage_full_d = accept | (stage_full_q & ~xfer);
    if (xfer)   active_d = stage_q;
    if (accept) stage_d  = S_DATA;
  end

  // Sample pipeline registers; reset drops any staged frame and recentres the active sample
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stage_q      <= '0;
      stage_full_q <= 1'b0;
      active_q     <= {CHANNELS{MID}};
    end else begin
      stage_q      <= stage_d;
      stage_full_q <= stage_full_d;
      active_q     <= active_d;
    end
  end

  // Tick-rate shared state: output bits and the loop order seen on the previous tick
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      DACout       <= {CHANNELS{INV}};
      order_last_q <= 1'b0;
    end else if (CE) begin
      DACout       <= dac_d;
      order_last_q <= ORDER2;
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic signed [AW-1:0] a1_q, a2_q, a1_d, a2_d, a1_n, a2_n;
    logic signed [SW-1:0] xs;
    logic signed [EW-1:0] x, fb, s1, s2;
    logic                 q_pos;

    assign xs    = signed'(active_q[ch*SW +: SW] ^ SIGN_FLIP);
    assign x     = MUTE ? '0 : signed'({{(EW-SW){xs[SW-1]}}, xs});
    // Quantiser looks at the pre-update loop-output accumulator
    assign q_pos = ORDER2 ? ~a2_q[AW-1] : ~a1_q[AW-1];
    assign fb    = q_pos ? FB_P : FB_N;
    assign s1    = signed'({{2{a1_q[AW-1]}}, a1_q}) + x - fb;
    assign a1_n  = sat(s1);
    assign s2    = signed'({{2{a2_q[AW-1]}}, a2_q}) + signed'({{2{a1_n[AW-1]}}, a1_n}) - fb;
    assign a2_n  = sat(s2);
    assign dac_d[ch] = q_pos ^ INV;

    // Loop update: restart from zero on an order change, otherwise integrate in the selected order
    always_comb begin
      a1_d = a1_n;
      a2_d = ORDER2 ? a2_n : '0;
      if (order_clear) begin
        a1_d = '0;
        a2_d = '0;
      end
    end

    // Accumulators advance only on modulator ticks
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        a1_q <= '0;
        a2_q <= '0;
      end else if (CE) begin
        a1_q <= a1_d;
        a2_q <= a2_d;
      end
    end
  end

endmodule

// File: tb/tb_sd_dac_multi.sv
// tb/tb_sd_dac_multi.sv - scoreboard bench for sd_dac_multi
module tb_sd_dac_multi;

  localparam int         CH   = 2;
  localparam int         SW   = 8;
  localparam logic       INV0 = 1'b1;
  localparam logic       INV1 = 1'b0;

  logic              CLK = 1'b0;
  logic              RESET, CE, ORDER2, MUTE, S_VALID;
  logic [CH*SW-1:0]  S_DATA;
  logic              S_READY0, S_READY1;
  logic [CH-1:0]     DAC0, DAC1;

  sd_dac_multi #(.MSBI(7), .CHANNELS(CH), .INV(INV0), .SIGNED_IN(1'b0)) u0 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .ORDER2(ORDER2), .MUTE(MUTE),
    .S_VALID(S_VALID), .S_READY(S_READY0), .S_DATA(S_DATA), .DACout(DAC0)
  );

  sd_dac_multi #(.MSBI(7), .CHANNELS(CH), .INV(INV1), .SIGNED_IN(1'b1)) u1 (
    .CLK(CLK), .RESET(RESET), .CE(CE), .ORDER2(ORDER2), .MUTE(MUTE),
    .S_VALID(S_VALID), .S_READY(S_READY1), .S_DATA(S_DATA), .DACout(DAC1)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    string      name;
    int         kind;
    logic [1:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tot0[CH];
  int   tot1[CH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic expect_at(input int delta, input string name, input int kind, input logic [1:0] val);
    exp_t e;
    int   i;
    e.cyc  = cyc + delta;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= e.cyc) i++;
    exp_q.insert(i, e);
  endtask

  task automatic expect_dac(input int delta, input string name, input logic raw);
    expect_at(delta, name, 0, {2{raw ^ INV0}});
    expect_at(delta, name, 1, {2{raw ^ INV1}});
  endtask

  task automatic expect_rdy(input int delta, input string name, input logic v);
    expect_at(delta, name, 2, {1'b0, v});
    expect_at(delta, name, 3, {1'b0, v});
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Called at a negedge; waits for room, offers one frame, checks the ready handshake
  task automatic send(input logic [CH*SW-1:0] d, input logic xfer_next);
    int n;
    n = 0;
    while (!S_READY0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 100) chk("send_timeout", n, 0);
    S_VALID = 1'b1;
    S_DATA  = d;
    expect_rdy(1, "rdy_drop", 1'b0);
    expect_rdy(2, "rdy_after_xfer", xfer_next);
    @(negedge CLK);
    S_VALID = 1'b0;
  endtask

  // Monitor: cycle counter, ones density per CE tick, and scoreboard pops
  initial begin
    exp_t e;
    int   act;
    logic ce_s, rst_s;
    for (int c = 0; c < CH; c++) begin
      tot0[c] = 0;
      tot1[c] = 0;
    end
    forever begin
      @(posedge CLK);
      cyc++;
      ce_s  = CE;
      rst_s = RESET;
      #1;
      if (ce_s && !rst_s) begin
        for (int c = 0; c < CH; c++) begin
          tot0[c] += int'(DAC0[c] ^ INV0);
          tot1[c] += int'(DAC1[c] ^ INV1);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        case (e.kind)
          0:       act = int'(DAC0);
          1:       act = int'(DAC1);
          2:       act = int'(S_READY0);
          default: act = int'(S_READY1);
        endcase
        if (e.cyc != cyc) chk({e.name, "_missed_cycle"}, e.cyc, cyc);
        else              chk(e.name, act, int'(e.val));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int         b0[CH];
    int         b1[CH];
    int         acc, fcnt, v, prev, mn, mx, step;
    logic       will_acc;
    logic [7:0] fb8;

    RESET = 1'b1; CE = 1'b0; ORDER2 = 1'b0; MUTE = 1'b0;
    S_VALID = 1'b0; S_DATA = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_dac0", int'(DAC0), 3);
    chk("rst_dac1", int'(DAC1), 0);
    chk("rst_rdy0", int'(S_READY0), 0);
    chk("rst_rdy1", int'(S_READY1), 0);

    // Midscale after reset: first-order loop alternates starting with q = +1
    RESET = 1'b0;
    CE    = 1'b1;
    expect_rdy(1, "rdy_after_rst", 1'b1);
    for (int k = 1; k <= 8; k++) expect_dac(k, "alt_mid", logic'(k % 2));
    ticks(8);

    // 0x80: 256 ones per 512 ticks
    send({2{8'h80}}, 1'b1);
    ticks(8);
    b0 = tot0;
    ticks(512);
    chk_rng("dens80_ch0", tot0[0] - b0[0], 254, 258);
    chk_rng("dens80_ch1", tot0[1] - b0[1], 254, 258);

    // 0xC0: 768 ones per 1024 ticks, first and second order
    send({2{8'hC0}}, 1'b1);
    ticks(16);
    b0 = tot0;
    ticks(1024);
    chk_rng("densC0_o1_ch0", tot0[0] - b0[0], 766, 770);
    chk_rng("densC0_o1_ch1", tot0[1] - b0[1], 766, 770);
    ORDER2 = 1'b1;
    ticks(32);
    b0 = tot0;
    ticks(1024);
    chk_rng("densC0_o2_ch0", tot0[0] - b0[0], 766, 770);
    chk_rng("densC0_o2_ch1", tot0[1] - b0[1], 766, 770);

    // 0x00: no ones once settled
    ORDER2 = 1'b0;
    send({2{8'h00}}, 1'b1);
    ticks(8);
    b0 = tot0;
    ticks(256);
    chk("dens00_ch0", tot0[0] - b0[0], 0);
    chk("dens00_ch1", tot0[1] - b0[1], 0);

    // S_VALID held high, CE every 4th cycle: one frame per tick, counter frames in order
    acc  = 0;
    fcnt = 0;
    S_DATA  = {2{8'h80}};
    for (int k = 0; k < 40; k++) begin
      CE      = ((k % 4) == 3);
      S_VALID = 1'b1;
      expect_rdy(1, "rdy_ce4", logic'((k % 4) == 3));
      will_acc = S_READY0;
      @(negedge CLK);
      if (will_acc) begin
        acc++;
        fcnt++;
        fb8    = 8'h80 + 8'(fcnt);
        S_DATA = {2{fb8}};
      end
    end
    S_VALID = 1'b0;
    CE      = 1'b1;
    chk("ce4_accepts", acc, 10);
    chk("ce4_last_frame", int'(u0.active_q), 16'h8989);

    // Signed 0x7F: ~255/256 ones, then MUTE drops to 50%
    send({2{8'h7F}}, 1'b1);
    ticks(16);
    b1 = tot1;
    ticks(256);
    chk_rng("dens7F_ch0", tot1[0] - b1[0], 253, 257);
    chk_rng("dens7F_ch1", tot1[1] - b1[1], 253, 257);
    MUTE = 1'b1;
    ticks(4);
    b1 = tot1;
    ticks(64);
    chk_rng("mute_ch0", tot1[0] - b1[0], 30, 34);
    chk_rng("mute_ch1", tot1[1] - b1[1], 30, 34);
    send({2{8'h12}}, 1'b1);
    ticks(2);
    MUTE = 1'b0;

    // 0xFF second order: A2 stays clamped within +/-1024, no wrap jumps
    send({2{8'hFF}}, 1'b1);
    ORDER2 = 1'b1;
    mn = 0; mx = 0; step = 0; prev = 0;
    for (int k = 0; k < 4096; k++) begin
      @(negedge CLK);
      v = int'(u0.g_ch[0].a2_q);
      if (v > mx) mx = v;
      if (v < mn) mn = v;
      if (v - prev > step) step = v - prev;
      if (prev - v > step) step = prev - v;
      prev = v;
    end
    chk_rng("a2_max", mx, 0, 1024);
    chk_rng("a2_min", mn, -1024, 0);
    chk_rng("a2_step", step, 0, 1152);

    // Order toggles clear both accumulators on the next tick
    ORDER2 = 1'b0;
    @(negedge CLK);
    chk("clr_o2to1_a1", int'(u0.g_ch[0].a1_q), 0);
    chk("clr_o2to1_a2", int'(u0.g_ch[0].a2_q), 0);
    ticks(3);
    ORDER2 = 1'b1;
    @(negedge CLK);
    chk("clr_o1to2_a1", int'(u0.g_ch[0].a1_q), 0);
    chk("clr_o1to2_a2", int'(u0.g_ch[0].a2_q), 0);
    ORDER2 = 1'b0;
    ticks(4);

    // Asynchronous reset with a staged frame: immediate outputs, frame discarded
    CE = 1'b0;
    send({2{8'h00}}, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_dac0", int'(DAC0), 3);
    chk("arst_dac1", int'(DAC1), 0);
    chk("arst_rdy0", int'(S_READY0), 0);
    chk("arst_rdy1", int'(S_READY1), 0);
    @(negedge CLK);
    RESET = 1'b0;
    CE    = 1'b1;
    for (int k = 1; k <= 6; k++) expect_dac(k, "post_arst_alt", logic'(k % 2));
    expect_rdy(1, "post_arst_rdy_tick", 1'b1);
    #1;
    chk("post_arst_rdy0", int'(S_READY0), 1);
    @(negedge CLK);
    ticks(7);

    CE = 1'b0;
    repeat (3) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_dac_multi.md
SD_DAC_MULTI -- requirements
Module: sd_dac_multi

Interface
REQ-001 SHALL have parameter MSBI, 7: highest sample bit index (sample width MSBI+1).
REQ-002 SHALL have parameter CHANNELS, 2: channel count, legal range 1..8.
REQ-003 SHALL have parameter INV, 1'b1: inversion applied to every DACout bit.
REQ-004 SHALL have parameter SIGNED_IN, 1'b0: 1 = two's-complement samples, 0 = excess-2**MSBI samples.
REQ-005 SHALL have port CLK, input, 1: clock; all state on rising edge.
REQ-006 SHALL have port RESET, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port CE, input, 1: modulator tick enable.
REQ-008 SHALL have port ORDER2, input, 1: 0 = first-order loop, 1 = second-order loop, all channels.
REQ-009 SHALL have port MUTE, input, 1: force modulator input to midscale.
REQ-010 SHALL have port S_VALID, input, 1: sample frame valid.
REQ-011 SHALL have port S_READY, output, 1: staging register empty.
REQ-012 SHALL have port S_DATA, input, CHANNELS*(MSBI+1): channel n at bits [n*(MSBI+1)+MSBI : n*(MSBI+1)].
REQ-013 SHALL have port DACout, output reg, CHANNELS: per-channel 1-bit stream to analog lowpass.

Function
REQ-014 Frame accepted on a cycle with S_VALID & S_READY; written to the staging register; S_READY low from the next cycle.
REQ-015 On a cycle with CE=1 and staging full, staging SHALL move to the active register and S_READY SHALL be high on the next cycle.
REQ-016 Accept and transfer in the same cycle: the transfer takes the old staging contents, the new frame lands in staging, and S_READY stays low.
REQ-017 Active register SHALL hold its value until replaced; no transfer while staging is empty.
REQ-018 Internal value x per channel: SIGNED_IN=0 -> x = sample - 2**MSBI; SIGNED_IN=1 -> x = sample; range [-2**MSBI, 2**MSBI-1].
REQ-019 MUTE=1 SHALL force x = 0 for every channel, sampled on each CE tick; staging/handshake unaffected.
REQ-020 Per channel, signed accumulators A1 and A2, each MSBI+5 bits; q = +1 if the loop-output accumulator >= 0, else -1; fb = q*2**MSBI.
REQ-021 First order, on each CE tick: A1 <= A1 + x - fb, with q taken from A1; A2 held at 0.
REQ-022 Second order, on each CE tick: A1' = A1 + x - fb; A2 <= A2 + A1' - fb; A1 <= A1'; q taken from A2.
REQ-023 A1 and A2 SHALL saturate at +/-2**(MSBI+3) instead of wrapping.
REQ-024 On each CE tick, DACout[n] SHALL register (q==+1) ^ INV using q from the pre-update accumulator; with CE=0, all state and DACout SHALL hold.
REQ-025 A change of ORDER2 relative to its last-tick value SHALL clear A1 and A2 to 0 on the next CE tick, in place of the update; DACout updates normally on that tick.
REQ-026 Over any 2**(MSBI+1) consecutive CE ticks with constant x, the count of DACout bits that are 1 after removing INV SHALL be within +/-2 of (x + 2**MSBI)/2**(MSBI+1) * ticks.
REQ-027 Latency: a frame accepted at cycle t reaches the active register on the first CE tick at or after t+1, affects the accumulators on the next CE tick, and affects DACout one cycle after that.

Reset
REQ-028 RESET high SHALL immediately set A1 = A2 = 0, staging empty, active register = midscale (x = 0), and DACout = {CHANNELS{INV}}; S_READY SHALL be 0 while RESET is asserted.
REQ-029 RESET assertion mid-frame SHALL discard staged data without a transfer; S_READY SHALL be 1 on the first cycle after RESET deasserts.
REQ-030 The stored last-tick ORDER2 value SHALL reset to 0.

Verification
REQ-031 MSBI=7, SIGNED_IN=0, CE=1, ORDER2=0, frame 8'h80 on all channels -> DACout alternates, 256 ones per 512 ticks (+/-2 per REQ-026).
REQ-032 Frame 8'hC0, first and second order, 1024 ticks each -> 768 ones +/-2; frame 8'h00 -> no ones after the first 8 ticks.
REQ-033 S_VALID held high, CE pulsed every 4 cycles -> exactly one frame accepted per CE tick; no loss or duplication of a frame counter.
REQ-034 SIGNED_IN=1, frame 8'h7F, then MUTE=1 mid-run -> density of ~255/256 becomes 50% within 4 ticks; S_READY timing unchanged.
REQ-035 Frame 8'hFF with ORDER2=1 for 4096 ticks -> A2 clamps at +/-2**10 and never wraps; toggling ORDER2 clears A1 and A2 to 0 on the next tick.
REQ-036 RESET pulsed asynchronously between clock edges with staging full -> DACout = INV and S_READY = 0 immediately; the staged frame is never applied.
